// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op-code constants and default widths for the ALU sharing block.
`default_nettype none
package alu_pkg;
  localparam int DW_DEF  = 32;
  localparam int OPW_DEF = 4;

  localparam logic [3:0] ALU_OP_ADD   = 4'b0000;
  localparam logic [3:0] ALU_OP_SUB   = 4'b0001;
  localparam logic [3:0] ALU_OP_AND   = 4'b0010;
  localparam logic [3:0] ALU_OP_OR    = 4'b0011;
  localparam logic [3:0] ALU_OP_XOR   = 4'b0100;
  localparam logic [3:0] ALU_OP_SLL   = 4'b0101;
  localparam logic [3:0] ALU_OP_SRL   = 4'b0110;
  localparam logic [3:0] ALU_OP_SRA   = 4'b0111;
  localparam logic [3:0] ALU_OP_PASSB = 4'b1000;
endpackage
`default_nettype wire

// File: rtl/alu_rsp_slot.sv
// alu_rsp_slot: single-entry valid/ready result register; a load wins over a drain.
`default_nettype none
module alu_rsp_slot #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_free
);
  logic          r_valid;
  logic [DW-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Slot can accept a new result if empty or being drained this cycle.
  assign o_free  = !r_valid | i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule
`default_nettype wire

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one combinational ALU between two requesters.
`default_nettype none
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int OPW = OPW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic [OPW-1:0] req0_op,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  input  logic [OPW-1:0] req1_op,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic [DW-1:0]  rsp0_data,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [DW-1:0]  rsp1_data,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  alu_c,
  output logic           grant_id
);
  logic r_prio;
  logic w_free0, w_free1;
  logic w_elig0, w_elig1;
  logic w_gnt_vld, w_gnt_id;

  // Reset gating drops any grant while reset is asserted, even mid-cycle.
  assign w_elig0   = req0_valid & w_free0 & !rst;
  assign w_elig1   = req1_valid & w_free1 & !rst;
  assign w_gnt_vld = w_elig0 | w_elig1;
  assign w_gnt_id  = (w_elig0 & w_elig1) ? r_prio : w_elig1;

  assign req0_ready = w_gnt_vld & !w_gnt_id;
  assign req1_ready = w_gnt_vld &  w_gnt_id;
  assign grant_id   = w_gnt_id;

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = OPW'(ALU_OP_ADD);
    if (w_gnt_vld) begin
      if (w_gnt_id) begin
        alu_a  = req1_a;
        alu_b  = req1_b;
        alu_op = req1_op;
      end else begin
        alu_a  = req0_a;
        alu_b  = req0_b;
        alu_op = req0_op;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (w_gnt_vld) begin
      r_prio <= ~w_gnt_id;
    end
  end

  alu_rsp_slot #(.DW(DW)) u_slot0 (
    .clk     (clk),
    .rst     (rst),
    .i_load  (req0_ready),
    .i_data  (alu_c),
    .i_ready (rsp0_ready),
    .o_valid (rsp0_valid),
    .o_data  (rsp0_data),
    .o_free  (w_free0)
  );

  alu_rsp_slot #(.DW(DW)) u_slot1 (
    .clk     (clk),
    .rst     (rst),
    .i_load  (req1_ready),
    .i_data  (alu_c),
    .i_ready (rsp1_ready),
    .o_valid (rsp1_valid),
    .o_data  (rsp1_data),
    .o_free  (w_free1)
  );
endmodule
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed and randomized checks of alu_share_arb against a reference model.
`default_nettype none
module tb_alu_share_arb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_v   = '0;
  logic [1:0]  rsp_rdy = '0;
  logic [31:0] ra [2];
  logic [31:0] rb [2];
  logic [3:0]  rop [2];
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, grant_id;
  logic [31:0] rsp0_data, rsp1_data, alu_a, alu_b, alu_c;
  logic [3:0]  alu_op;

  int n_cmp = 0;
  int n_mis = 0;
  int last_g = -1;
  int m_prio = 0;
  bit m_rv [2];
  logic [31:0] m_rd [2];

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return $unsigned($signed(a) >>> b[4:0]);
      4'd8: return b;
      default: return a;
    endcase
  endfunction

  assign alu_c = alu_ref(alu_a, alu_b, alu_op);

  alu_share_arb dut (
    .clk(clk), .rst(rst),
    .req0_valid(req_v[0]), .req0_ready(req0_ready), .req0_a(ra[0]), .req0_b(rb[0]), .req0_op(rop[0]),
    .req1_valid(req_v[1]), .req1_ready(req1_ready), .req1_a(ra[1]), .req1_b(rb[1]), .req1_op(rop[1]),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp_rdy[0]), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp_rdy[1]), .rsp1_data(rsp1_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c), .grant_id(grant_id)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_prio = 0;
    for (int i = 0; i < 2; i++) begin
      m_rv[i] = 1'b0;
      m_rd[i] = '0;
    end
  endtask

  // One clock: check combinational outputs, advance the model, check responses.
  task automatic cycle();
    int g;
    logic [31:0] ea, eb;
    logic [3:0]  eo;
    #1;
    g = -1;
    for (int k = 0; k < 2; k++) begin
      int idx;
      idx = (m_prio + k) % 2;
      if (g < 0 && req_v[idx] && (!m_rv[idx] || rsp_rdy[idx])) g = idx;
    end
    ea = (g >= 0) ? ra[g]  : 32'd0;
    eb = (g >= 0) ? rb[g]  : 32'd0;
    eo = (g >= 0) ? rop[g] : 4'd0;
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, g == 0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, g == 1});
    if (g >= 0) chk("grant_id", {31'd0, grant_id}, g[31:0]);
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, eb);
    chk("alu_op", {28'd0, alu_op}, {28'd0, eo});
    last_g = g;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (g == i) begin
        m_rv[i] = 1'b1;
        m_rd[i] = alu_ref(ra[i], rb[i], rop[i]);
      end else if (rsp_rdy[i]) begin
        m_rv[i] = 1'b0;
      end
    end
    if (g >= 0) m_prio = 1 - g;
    #1;
    chk("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, m_rv[0]});
    chk("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, m_rv[1]});
    chk("rsp0_data", rsp0_data, m_rd[0]);
    chk("rsp1_data", rsp1_data, m_rd[1]);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op);
    req_v[i] = v;
    ra[i]    = a;
    rb[i]    = b;
    rop[i]   = op;
  endtask

  initial begin
    int prev;
    model_reset();
    set_req(0, 1'b1, 32'd5, 32'd3, 4'd0);
    set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
    rsp_rdy = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("reset_rsp0_data", rsp0_data, 32'd0);
    chk("reset_req0_ready", {31'd0, req0_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single requester add.
    cycle();
    chk("first_grant", last_g, 0);
    chk("add_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("add_rsp0_data", rsp0_data, 32'd8);

    // Continuous contention alternates grants.
    set_req(0, 1'b1, 32'd10, 32'd4, 4'd1);
    set_req(1, 1'b1, 32'h8000_0000, 32'd4, 4'd7);
    prev = 0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("contend_alternate", {31'd0, last_g != prev}, 32'd1);
      prev = last_g;
    end
    chk("contend_rsp0", rsp0_data, 32'd6);
    chk("contend_rsp1", rsp1_data, 32'hF800_0000);

    // Full response slot blocks requester 1.
    req_v[0] = 1'b0;
    rsp_rdy  = 2'b01;
    cycle();
    cycle();
    #1;
    chk("stall_req1_ready", {31'd0, req1_ready}, 32'd0);
    chk("stall_alu_a", alu_a, 32'd0);
    chk("stall_alu_op", {28'd0, alu_op}, 32'd0);
    cycle();
    rsp_rdy = 2'b11;
    #1;
    chk("unstall_req1_ready", {31'd0, req1_ready}, 32'd1);
    cycle();

    // Back-to-back on requester 0.
    req_v[1] = 1'b0;
    set_req(0, 1'b1, 32'd1, 32'd31, 4'd5);
    cycle();
    chk("b2b_sll", rsp0_data, 32'h8000_0000);
    set_req(0, 1'b1, 32'hFF, 32'h0F, 4'd4);
    cycle();
    chk("b2b_xor", rsp0_data, 32'hF0);
    chk("b2b_valid", {31'd0, rsp0_valid}, 32'd1);

    // Randomized traffic respecting hold-until-accepted.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req_v[i] || last_g == i) begin
          req_v[i] = ($urandom_range(0, 3) != 0);
          ra[i]    = $urandom();
          rb[i]    = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 31));
          rop[i]   = 4'($urandom_range(0, 11));
        end
      end
      rsp_rdy = 2'($urandom_range(0, 3));
      cycle();
    end

    // Asynchronous reset during a grant with a held response.
    req_v   = 2'b00;
    rsp_rdy = 2'b11;
    cycle();
    set_req(0, 1'b1, 32'd1, 32'd2, 4'd0);
    rsp_rdy = 2'b00;
    cycle();
    rsp_rdy = 2'b01;
    #1;
    chk("pre_rst_grant", {31'd0, req0_ready}, 32'd1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b0;
    req_v = 2'b00;
    cycle();
    cycle();
    set_req(0, 1'b1, 32'd7, 32'd1, 4'd1);
    set_req(1, 1'b1, 32'd7, 32'd1, 4'd0);
    rsp_rdy = 2'b11;
    cycle();
    chk("post_rst_prio", last_g, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one combinational 32-bit ALU (add/sub/and/or/xor/sll/srl/sra/pass-b) between two requesters, for example the EX stage and an address/branch helper.
- Arbitrates round-robin, drives the shared ALU inputs, and captures the result into a per-requester response register.
- Every request and response channel uses a valid/ready handshake.
- Sits between the requesters and the single ALU instance in the pipeline datapath.

Parameters:
- DW, 32, operand/result width.
- OPW, 4, ALU op code width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle when valid&ready.
- req0_a  in  DW  operand a.
- req0_b  in  DW  operand b.
- req0_op  in  OPW  ALU op code.
- req1_valid / req1_ready / req1_a / req1_b / req1_op  same as requester 0, for requester 1.
- rsp0_valid  out  1  result for requester 0 held.
- rsp0_ready  in  1  requester 0 consumes result.
- rsp0_data  out  DW  result for requester 0.
- rsp1_valid / rsp1_ready / rsp1_data  same as requester 0, for requester 1.
- alu_a  out  DW  shared ALU operand a.
- alu_b  out  DW  shared ALU operand b.
- alu_op  out  OPW  shared ALU op code.
- alu_c  in  DW  shared ALU result, combinational from alu_a/alu_b/alu_op.
- grant_id  out  1  requester granted this cycle; valid only when a grant occurs.

Behaviour:
- Reset values: rsp0_valid=0, rsp1_valid=0, rsp0_data=0, rsp1_data=0, priority pointer prio=0.
  - Reset is asynchronous; asserting it mid-operation discards held results and any same-cycle grant.
- Slot free condition: free_i = !rspi_valid | rspi_ready. A requester whose response slot is full and not being drained is not eligible.
- Eligibility: elig_i = reqi_valid & free_i.
- Grant:
  - Only one eligible requester: it wins, regardless of prio.
  - Both eligible: requester prio wins.
  - At most one grant per cycle.
- Ready outputs:
  - reqi_ready = 1 only for the granted requester, computed combinationally in the same cycle.
  - A requester's ready may depend on its own valid.
- ALU drive, combinational:
  - Grant present: alu_a/alu_b/alu_op come from the granted requester.
  - No grant: alu_a=0, alu_b=0, alu_op=4'b0000 (add).
- Result capture: on a grant to i, rspi_data <= alu_c and rspi_valid <= 1 at the next edge.
  - Latency: request accepted in cycle N gives rspi_valid=1 in cycle N+1.
- Response drain:
  - rspi_valid & rspi_ready with no new grant to i: rspi_valid <= 0 and rspi_data holds its value.
  - Drain and new grant to i in the same cycle: the new result overwrites, rspi_valid stays 1 (back-to-back throughput of 1 per cycle per requester).
- Pointer update: on a grant to i, prio <= ~i. With no grant, prio holds. Consequence: under continuous contention, grants alternate 0,1,0,1...
- Stability rules:
  - A requester must hold valid/a/b/op stable until accepted.
  - Responses stay stable while valid & !ready.
- Op encodings passed through unchanged:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor.
  - 0101 sll, 0110 srl, 0111 sra; shift amount is b[4:0].
  - 1000 pass b.
  - Other codes: the ALU returns a.
  - The arbiter does not decode ops.
- State: prio (1 bit) plus two response registers. No other FSM is required.

Decomposition:
- Shared package `alu_pkg`: ALU_OP_ADD..ALU_OP_PASSB 4-bit constants, DW/OPW defaults.
- One natural sub-module, `alu_rsp_slot`: a single-entry valid/ready result holding register, instantiated twice.
- Arbitration logic stays in the top module.

Test Plan:
- Reset held with req0_valid=1 -> rsp0_valid=0, rsp0_data=0, req0_ready=0. After release, first grant goes to 0.
- req0 only: a=5, b=3, op=add -> req0_ready=1 in cycle N; rsp0_valid=1, rsp0_data=8 in cycle N+1; grant_id=0.
- Both valid for 4 cycles with rsp ready=1; req0 sub 10-4, req1 sra a=0x80000000 b=4 -> grants alternate 0,1,0,1; rsp0_data=6, rsp1_data=0xF8000000.
- rsp1_ready=0 while rsp1 full, req1 valid, req0 idle -> req1_ready=0, no grant, ALU driven 0/0/add. Raise rsp1_ready -> req1 granted in that same cycle.
- Back-to-back on req0 with rsp0_ready=1: sll 1<<31, then xor 0xFF^0x0F -> rsp0_data=0x80000000 then 0xF0, rsp0_valid continuous.
- Assert rst mid-stream while rsp0_valid=1 and a grant is in progress -> all rsp valid=0 immediately, prio=0, no result delivered after release.
